mc_control_hs: RTL and testbench

- Next-generation multicycle control FSM for the TSC CPU.
- Replaces fixed single-cycle memory timing with a req/ready memory handshake and a bounded wait-state timeout.
- Adds a sticky HALT state with an error flag and a retired-instruction counter.
- Sits between the IR/ALU-compare datapath and the datapath muxes/enables; all outputs except the counter and flags are decoded from the registered state.

---
 rtl/tsc_isa_pkg.sv | 78 +++++++
 rtl/mc_decode.sv | 131 +++++++++++++
 rtl/mc_control_hs.sv | 117 +++++++++++
 tb/tb_mc_control_hs.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tsc_isa_pkg.sv
// rtl/tsc_isa_pkg.sv - TSC ISA encodings, control field encodings and FSM state type
package tsc_isa_pkg;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_R   = 4'd15;

  // R-type function codes (IR[5:0]); arithmetic funcs 0..7 double as ALU ops
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // ALU operations used directly by the controller
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_LHI = 4'd8;

  // Datapath mux encodings
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_R2 = 2'd2;

  localparam logic [1:0] RSRC_ALU = 2'd0;
  localparam logic [1:0] RSRC_MDR = 2'd1;
  localparam logic [1:0] RSRC_PC1 = 2'd2;

  localparam logic SRC_A_PC = 1'b0;
  localparam logic SRC_A_RS = 1'b1;

  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_ONE  = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;
  localparam logic [1:0] SRC_B_ZERO = 2'd3;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       output_active;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational control decode from state, instruction fields and compare result
module mc_decode
  import tsc_isa_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FUNC_W   = 6
) (
  input  state_t              state_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [FUNC_W-1:0]   func_i,
  input  logic [1:0]          alu_cmp_i,
  output ctrl_t               ctrl_o,
  output state_t              nxt_o,
  output logic                retire_o
);

  logic is_bne, is_beq, is_bgz, is_blz, is_adi, is_ori, is_lhi, is_lwd, is_swd, is_jmp, is_jal, is_r;
  logic is_arith, is_jpr, is_jrl, is_wwd, is_hlt, is_br, is_mem, go_ex, taken;

  assign is_bne = (opcode_i == OPCODE_W'(OP_BNE));
  assign is_beq = (opcode_i == OPCODE_W'(OP_BEQ));
  assign is_bgz = (opcode_i == OPCODE_W'(OP_BGZ));
  assign is_blz = (opcode_i == OPCODE_W'(OP_BLZ));
  assign is_adi = (opcode_i == OPCODE_W'(OP_ADI));
  assign is_ori = (opcode_i == OPCODE_W'(OP_ORI));
  assign is_lhi = (opcode_i == OPCODE_W'(OP_LHI));
  assign is_lwd = (opcode_i == OPCODE_W'(OP_LWD));
  assign is_swd = (opcode_i == OPCODE_W'(OP_SWD));
  assign is_jmp = (opcode_i == OPCODE_W'(OP_JMP));
  assign is_jal = (opcode_i == OPCODE_W'(OP_JAL));
  assign is_r   = (opcode_i == OPCODE_W'(OP_R));

  assign is_arith = is_r && (func_i <= FUNC_W'(FN_SHR));
  assign is_jpr   = is_r && (func_i == FUNC_W'(FN_JPR));
  assign is_jrl   = is_r && (func_i == FUNC_W'(FN_JRL));
  assign is_wwd   = is_r && (func_i == FUNC_W'(FN_WWD));
  assign is_hlt   = is_r && (func_i == FUNC_W'(FN_HLT));

  assign is_br  = is_bne || is_beq || is_bgz || is_blz;
  assign is_mem = is_lwd || is_swd;
  assign go_ex  = is_arith || is_adi || is_ori || is_lhi || is_mem || is_br;

  // alu_cmp: 00 zero, 01 other non-zero, 10 positive, 11 negative
  assign taken = (is_bne && (alu_cmp_i != 2'b00)) || (is_beq && (alu_cmp_i == 2'b00)) ||
                 (is_bgz && (alu_cmp_i == 2'b10)) || (is_blz && (alu_cmp_i == 2'b11));

  // Controls for the current state; IF/MEM values assume the handshake completes this cycle
  always_comb begin
    ctrl_o   = '0;
    nxt_o    = state_i;
    retire_o = 1'b0;
    case (state_i)
      S_IF: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_src    = PC_SEQ;
        ctrl_o.alu_src_a = SRC_A_PC;
        ctrl_o.alu_src_b = SRC_B_ONE;
        ctrl_o.alu_op    = ALU_ADD;
        nxt_o            = S_ID;
      end
      S_ID: begin
        ctrl_o.alu_src_a = SRC_A_PC;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_ADD;
        nxt_o            = S_IF;
        if (is_jmp || is_jal) begin
          ctrl_o.pc_src   = PC_JUMP;
          ctrl_o.pc_write = 1'b1;
          retire_o        = 1'b1;
        end
        if (is_jpr || is_jrl) begin
          ctrl_o.pc_src   = PC_REG;
          ctrl_o.pc_write = 1'b1;
          retire_o        = 1'b1;
        end
        if (is_jal || is_jrl) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = DST_R2;
          ctrl_o.reg_src   = RSRC_PC1;
        end
        if (is_wwd) begin
          ctrl_o.output_active = 1'b1;
          retire_o             = 1'b1;
        end
        if (is_hlt) begin
          nxt_o    = S_HALT;
          retire_o = 1'b1;
        end
        if (go_ex) nxt_o = S_EX;
      end
      S_EX: begin
        ctrl_o.alu_src_a = SRC_A_RS;
        if (is_br) begin
          ctrl_o.alu_op    = ALU_SUB;
          ctrl_o.alu_src_b = (is_bne || is_beq) ? SRC_B_RT : SRC_B_ZERO;
          ctrl_o.pc_src    = PC_BRANCH;
          ctrl_o.pc_write  = taken;
          retire_o         = 1'b1;
          nxt_o            = S_IF;
        end else if (is_arith) begin
          ctrl_o.alu_src_b = SRC_B_RT;
          ctrl_o.alu_op    = 4'(func_i);
          nxt_o            = S_WB;
        end else begin
          ctrl_o.alu_src_b = SRC_B_IMM;
          ctrl_o.alu_op    = is_ori ? ALU_ORR : (is_lhi ? ALU_LHI : ALU_ADD);
          nxt_o            = is_mem ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
        ctrl_o.mem_we  = is_swd;
        retire_o       = is_swd;
        nxt_o          = is_swd ? S_IF : S_WB;
      end
      S_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = is_r ? DST_RD : DST_RT;
        ctrl_o.reg_src   = is_lwd ? RSRC_MDR : RSRC_ALU;
        retire_o         = 1'b1;
        nxt_o            = S_IF;
      end
      S_HALT: nxt_o = S_HALT;
      default: nxt_o = S_IF;
    endcase
  end

endmodule

// File: rtl/mc_control_hs.sv
// rtl/mc_control_hs.sv - multicycle TSC control FSM with memory handshake, timeout halt and retire counter
module mc_control_hs
  import tsc_isa_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FUNC_W   = 6,
  parameter int ICNT_W   = 16,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   func,
  input  logic [1:0]          alu_cmp,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          reg_src,
  output logic [3:0]          alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                output_active,
  output logic                inst_retired,
  output logic [ICNT_W-1:0]   num_inst,
  output logic                is_halted,
  output logic                mem_err
);

  state_t              state_q, state_d, dec_nxt;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ICNT_W-1:0]   icnt_q;
  logic                err_q, err_d;
  logic                dec_retire, retire;
  logic                handshake;
  ctrl_t               dec_ctrl, ctl;

  mc_decode #(
    .OPCODE_W (OPCODE_W),
    .FUNC_W   (FUNC_W)
  ) u_decode (
    .state_i   (state_q),
    .opcode_i  (opcode),
    .func_i    (func),
    .alu_cmp_i (alu_cmp),
    .ctrl_o    (dec_ctrl),
    .nxt_o     (dec_nxt),
    .retire_o  (dec_retire)
  );

  assign handshake = (state_q == S_IF) || (state_q == S_MEM);

  // Stall/timeout handling over the decoded controls; all outputs forced low while in reset
  always_comb begin
    ctl     = dec_ctrl;
    retire  = dec_retire;
    state_d = dec_nxt;
    wait_d  = wait_q;
    err_d   = err_q;
    if (handshake && !mem_ready) begin
      ctl.pc_write = 1'b0;
      retire       = 1'b0;
      state_d      = state_q;
      if (wait_q == WAIT_W'(WAIT_MAX)) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
    if (state_d != state_q) wait_d = '0;
    if (!reset_n) begin
      ctl    = '0;
      retire = 1'b0;
    end
  end

  // State, wait counter, sticky error and retired-instruction counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
      wait_q  <= '0;
      err_q   <= 1'b0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (retire) icnt_q <= icnt_q + 1'b1;
    end
  end

  assign mem_req       = ctl.mem_req;
  assign mem_we        = ctl.mem_we;
  assign iord          = ctl.iord;
  assign ir_write      = ctl.ir_write;
  assign pc_write      = ctl.pc_write;
  assign pc_src        = ctl.pc_src;
  assign reg_write     = ctl.reg_write;
  assign reg_dst       = ctl.reg_dst;
  assign reg_src       = ctl.reg_src;
  assign alu_op        = ctl.alu_op;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign output_active = ctl.output_active;
  assign inst_retired  = retire;
  assign num_inst      = icnt_q;
  assign is_halted     = reset_n && (state_q == S_HALT);
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mc_control_hs.sv
// tb/tb_mc_control_hs.sv - directed self-checking bench for mc_control_hs
module tb_mc_control_hs;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       output_active;
    logic       inst_retired;
    logic       is_halted;
    logic       mem_err;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic [1:0]  alu_cmp;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic [1:0]  pc_src, reg_dst, reg_src, alu_src_b;
  logic [3:0]  alu_op;
  logic        alu_src_a, output_active, inst_retired, is_halted, mem_err;
  logic [15:0] num_inst;
  obs_t        cur;
  obs_t        e;
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  mc_control_hs dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func), .alu_cmp(alu_cmp),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .reg_src(reg_src), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .output_active(output_active), .inst_retired(inst_retired),
    .num_inst(num_inst), .is_halted(is_halted), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  assign cur = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst, reg_src,
                alu_op, alu_src_a, alu_src_b, output_active, inst_retired, is_halted, mem_err};

  function automatic obs_t e_if(logic rdy);
    obs_t r = '0;
    r.mem_req = 1'b1; r.ir_write = 1'b1; r.alu_src_b = 2'd1; r.pc_write = rdy;
    return r;
  endfunction

  function automatic obs_t e_id();
    obs_t r = '0;
    r.alu_src_b = 2'd2;
    return r;
  endfunction

  function automatic obs_t e_ex(logic [1:0] src_b, logic [3:0] op);
    obs_t r = '0;
    r.alu_src_a = 1'b1; r.alu_src_b = src_b; r.alu_op = op;
    return r;
  endfunction

  function automatic obs_t e_mem(logic we);
    obs_t r = '0;
    r.mem_req = 1'b1; r.iord = 1'b1; r.mem_we = we;
    return r;
  endfunction

  function automatic obs_t e_wb(logic [1:0] dst, logic [1:0] src);
    obs_t r = '0;
    r.reg_write = 1'b1; r.reg_dst = dst; r.reg_src = src; r.inst_retired = 1'b1;
    return r;
  endfunction

  function automatic obs_t e_halt(logic err);
    obs_t r = '0;
    r.is_halted = 1'b1; r.mem_err = err;
    return r;
  endfunction

  // Called just after inputs change on a falling edge; checks, then advances one cycle
  task automatic look(input string tag, input obs_t exp_v);
    #1;
    total++;
    assert (cur === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, cur, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic cnum(input string tag, input int exp_n);
    #1;
    total++;
    assert (int'(num_inst) === exp_n) passed++;
    else begin
      failed++;
      $error("FAIL %s num_inst observed=%0d expected=%0d", tag, num_inst, exp_n);
    end
  endtask

  initial begin
    reset_n = 1'b0; opcode = 4'd4; func = 6'd0; alu_cmp = 2'b00; mem_ready = 1'b1;
    look("reset_outputs_zero", '0);
    cnum("reset_count", 0);

    // ADI with ready tied high: IF ID EX WB
    reset_n = 1'b1;
    look("adi_if", e_if(1'b1));
    look("adi_id", e_id());
    look("adi_ex", e_ex(2'd2, 4'd0));
    look("adi_wb", e_wb(2'd0, 2'd0));
    cnum("adi_count", 1);

    // LWD: IF waits 3 cycles, MEM waits 2 cycles
    opcode = 4'd7; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) look("lwd_if_wait", e_if(1'b0));
    mem_ready = 1'b1;
    look("lwd_if_ready", e_if(1'b1));
    look("lwd_id", e_id());
    look("lwd_ex", e_ex(2'd2, 4'd0));
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) look("lwd_mem_wait", e_mem(1'b0));
    mem_ready = 1'b1;
    look("lwd_mem_ready", e_mem(1'b0));
    look("lwd_wb", e_wb(2'd0, 2'd1));
    cnum("lwd_count", 2);

    // BEQ taken
    opcode = 4'd1; alu_cmp = 2'b00;
    look("beq_t_if", e_if(1'b1));
    look("beq_t_id", e_id());
    e = e_ex(2'd0, 4'd1); e.pc_src = 2'd1; e.pc_write = 1'b1; e.inst_retired = 1'b1;
    look("beq_t_ex", e);
    cnum("beq_t_count", 3);

    // BEQ not taken
    alu_cmp = 2'b01;
    look("beq_n_if", e_if(1'b1));
    look("beq_n_id", e_id());
    e = e_ex(2'd0, 4'd1); e.pc_src = 2'd1; e.inst_retired = 1'b1;
    look("beq_n_ex", e);
    cnum("beq_n_count", 4);

    // BGZ taken compares against zero
    opcode = 4'd2; alu_cmp = 2'b10;
    look("bgz_if", e_if(1'b1));
    look("bgz_id", e_id());
    e = e_ex(2'd3, 4'd1); e.pc_src = 2'd1; e.pc_write = 1'b1; e.inst_retired = 1'b1;
    look("bgz_ex", e);

    // JAL completes in ID with link write
    opcode = 4'd10;
    look("jal_if", e_if(1'b1));
    e = e_id(); e.pc_src = 2'd2; e.pc_write = 1'b1; e.reg_write = 1'b1;
    e.reg_dst = 2'd2; e.reg_src = 2'd2; e.inst_retired = 1'b1;
    look("jal_id", e);
    cnum("jal_count", 6);

    // WWD strobes the display in ID
    opcode = 4'd15; func = 6'd28;
    look("wwd_if", e_if(1'b1));
    e = e_id(); e.output_active = 1'b1; e.inst_retired = 1'b1;
    look("wwd_id", e);
    cnum("wwd_count", 7);

    // Fetch never answered: 16 IF cycles then timeout halt
    opcode = 4'd4; func = 6'd0; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) look("timeout_if_wait", e_if(1'b0));
    look("timeout_halt", e_halt(1'b1));
    mem_ready = 1'b1;
    look("timeout_halt_ignores_ready", e_halt(1'b1));
    cnum("timeout_count", 7);

    // Reset clears halt, error and count
    reset_n = 1'b0;
    look("reset2_outputs_zero", '0);
    cnum("reset2_count", 0);

    // Reset asserted mid-wait clears outputs immediately
    reset_n = 1'b1; mem_ready = 1'b0; opcode = 4'd15; func = 6'd29;
    for (int i = 0; i < 5; i++) look("midwait_if", e_if(1'b0));
    reset_n = 1'b0;
    look("midwait_reset_zero", '0);
    look("midwait_reset_hold_zero", '0);

    // Wait counter restarted: ready on the 16th cycle (limit) still advances
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) look("limit_if_wait", e_if(1'b0));
    mem_ready = 1'b1;
    look("limit_ready_wins", e_if(1'b1));
    e = e_id(); e.inst_retired = 1'b1;
    look("hlt_id", e);
    cnum("hlt_count", 1);

    // HLT: absorbing, no error flag, ready ignored
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      look("hlt_halted", e_halt(1'b0));
    end
    cnum("hlt_count_after", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
